mux_input_scanner: RTL and testbench
====================================

// Module: mux_input_scanner
// PURPOSE
// Scan controller for the front-panel 16:1 input multiplexer (5 encoders x A/B/button + 1 button).
// Steps MUX_ADDR, waits for mux/line settling, samples MUX_OUT, debounces each channel.
// Publishes a stable 16-bit input image with a per-scan change mask to the encoder decoders.
// PARAMETERS
// NUM_INPUTS     16    channels scanned, addresses 0..NUM_INPUTS-1
// ADDR_BITS      4     MUX_ADDR width, 2**ADDR_BITS >= NUM_INPUTS
// SETTLE_CYCLES  8     cycles per channel between address change and sample (>=3)
// DEBOUNCE_SCANS 4     consecutive differing samples needed to accept a change (>=1)
// SCAN_PERIOD    1000  clocks between scan start ticks (10us @100MHz)
// PORTS
// CLK          in   1           system clock, posedge
// RESET        in   1           synchronous reset, active high
// MUX_ADDR     out  ADDR_BITS   mux select, registered
// MUX_OUT      in   1           selected mux line, asynchronous
// STATE        out  NUM_INPUTS  debounced input image
// CHANGE_MASK  out  NUM_INPUTS  bits of STATE that changed in last completed scan
// SCAN_DONE    out  1           1-cycle pulse at end of each scan
// CHANGED      out  1           1-cycle pulse with SCAN_DONE when CHANGE_MASK != 0
// OVERRUN      out  1           sticky: scan tick arrived while a scan was in progress
// BEHAVIOUR
// - Reset (sync, one edge): MUX_ADDR=0, STATE=0, CHANGE_MASK=0, SCAN_DONE=0, CHANGED=0,
//   OVERRUN=0, FSM=IDLE, divider=0, settle counter=0, all debounce counters=0, sync FFs=0.
// - Reset mid-scan aborts the scan; no SCAN_DONE emitted for it.
// - MUX_OUT passes a 2-FF synchronizer; sampled value is synchronizer output.
// - Divider free-runs 0..SCAN_PERIOD-1; tick when divider==SCAN_PERIOD-1.
// - FSM IDLE: on tick -> SETTLE, MUX_ADDR=0, settle cnt=0, CHANGE_MASK cleared.
// - SETTLE: cnt increments; at cnt==SETTLE_CYCLES-1 -> SAMPLE.
// - SAMPLE (1 cycle): debounce update for channel MUX_ADDR; if MUX_ADDR==NUM_INPUTS-1 -> DONE,
//   else MUX_ADDR+1, cnt=0 -> SETTLE. Each channel occupies SETTLE_CYCLES+1 cycles.
// - DONE (1 cycle): SCAN_DONE=1, CHANGED=|CHANGE_MASK, MUX_ADDR=0 -> IDLE.
// - Tick in any state other than IDLE: ignored, OVERRUN<=1 (held until reset).
//   Tick in same cycle FSM enters IDLE from DONE is also an overrun.
// - Debounce per channel i, counter width clog2(DEBOUNCE_SCANS+1), at its SAMPLE:
//   s==STATE[i] -> cnt[i]=0; else if cnt[i]==DEBOUNCE_SCANS-1 -> STATE[i]=s, cnt[i]=0,
//   CHANGE_MASK[i]=1; else cnt[i]++. Counter never wraps.
// - DEBOUNCE_SCANS=1: change accepted on first differing sample.
// - STATE[i] updates on the clock edge ending its SAMPLE cycle; CHANGE_MASK valid from DONE
//   until next IDLE->SETTLE transition; STATE is always valid.
// - Multiple channels may change in one scan; all bits reported together.
// - Latency of a clean step on channel i: DEBOUNCE_SCANS scans plus sync/settle position.
// TESTING (bench params SCAN_PERIOD=200, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3 unless noted)
// - Reset release, inputs 0 -> MUX_ADDR 0..15 each held 5 cycles, SCAN_DONE every 200 clks,
//   STATE=0, CHANGE_MASK=0, CHANGED never, OVERRUN=0.
// - Input 5 steps to 1 -> STATE[5]=1 at 3rd scan after step, CHANGE_MASK=16'h0020 with CHANGED
//   for that scan only, next scan CHANGE_MASK=0.
// - Input 3 high for exactly 2 scans then low -> STATE[3] stays 0, CHANGE_MASK never nonzero.
// - Inputs 0,1,15 step together -> single scan reports CHANGE_MASK=16'h8003, STATE=16'h8003.
// - SCAN_PERIOD=60 (<16*5+2) -> OVERRUN=1 on first scan, scans still complete, sticky until RESET.
// - RESET asserted while MUX_ADDR==7 with STATE=16'hFFFF -> next cycle MUX_ADDR=0, STATE=0,
//   no SCAN_DONE; first post-reset scan needs full 3 scans to re-accept 1s.

Source files
------------

// File: rtl/mux_input_scanner.sv
// Front-panel 16:1 input mux scanner: steps the mux address, waits for settling, samples
// the synchronized line, debounces each channel and publishes a stable image plus change mask.
module mux_input_scanner #(
   parameter int NUM_INPUTS     = 16,
   parameter int ADDR_BITS      = 4,
   parameter int SETTLE_CYCLES  = 8,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int SCAN_PERIOD    = 1000
) (
   input  logic                  CLK,
   input  logic                  RESET,
   output logic [ADDR_BITS-1:0]  MUX_ADDR,
   input  logic                  MUX_OUT,
   output logic [NUM_INPUTS-1:0] STATE,
   output logic [NUM_INPUTS-1:0] CHANGE_MASK,
   output logic                  SCAN_DONE,
   output logic                  CHANGED,
   output logic                  OVERRUN
);

   localparam int DIV_BITS    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int SETTLE_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int DEB_BITS    = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [DIV_BITS-1:0]    DIV_LAST    = DIV_BITS'(SCAN_PERIOD - 1);
   localparam logic [SETTLE_BITS-1:0] SETTLE_LAST = SETTLE_BITS'(SETTLE_CYCLES - 1);
   localparam logic [DEB_BITS-1:0]    DEB_LAST    = DEB_BITS'(DEBOUNCE_SCANS - 1);
   localparam logic [ADDR_BITS-1:0]   ADDR_LAST   = ADDR_BITS'(NUM_INPUTS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } scan_state_t;

   scan_state_t           scan_state;
   logic [DIV_BITS-1:0]    divider;
   logic [SETTLE_BITS-1:0] settle_cnt;
   logic                   sync_meta;
   logic                   sync_out;
   logic [DEB_BITS-1:0]    deb_cnt [NUM_INPUTS];
   logic                   scan_tick;

   assign scan_tick = (divider == DIV_LAST);

   // Free-running scan period divider; it keeps counting whatever the FSM is doing.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         divider <= '0;
      end else if (scan_tick) begin
         divider <= '0;
      end else begin
         divider <= divider + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_meta <= 1'b0;
         sync_out  <= 1'b0;
      end else begin
         sync_meta <= MUX_OUT;
         sync_out  <= sync_meta;
      end
   end

   // Scan sequencer with per-channel debounce applied in that channel's SAMPLE cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         scan_state  <= IDLE;
         MUX_ADDR    <= '0;
         settle_cnt  <= '0;
         STATE       <= '0;
         CHANGE_MASK <= '0;
         SCAN_DONE   <= 1'b0;
         CHANGED     <= 1'b0;
         OVERRUN     <= 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         SCAN_DONE <= 1'b0;
         CHANGED   <= 1'b0;

         if (scan_tick && (scan_state != IDLE)) begin
            OVERRUN <= 1'b1;
         end

         case (scan_state)
            IDLE: begin
               if (scan_tick) begin
                  scan_state  <= SETTLE;
                  MUX_ADDR    <= '0;
                  settle_cnt  <= '0;
                  CHANGE_MASK <= '0;
               end
            end

            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  scan_state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            SAMPLE: begin
               for (int i = 0; i < NUM_INPUTS; i++) begin
                  if (MUX_ADDR == ADDR_BITS'(i)) begin
                     if (sync_out == STATE[i]) begin
                        deb_cnt[i] <= '0;
                     end else if (deb_cnt[i] == DEB_LAST) begin
                        STATE[i]       <= sync_out;
                        deb_cnt[i]     <= '0;
                        CHANGE_MASK[i] <= 1'b1;
                     end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                     end
                  end
               end
               if (MUX_ADDR == ADDR_LAST) begin
                  scan_state <= DONE;
               end else begin
                  MUX_ADDR   <= MUX_ADDR + 1'b1;
                  settle_cnt <= '0;
                  scan_state <= SETTLE;
               end
            end

            DONE: begin
               SCAN_DONE  <= 1'b1;
               CHANGED    <= |CHANGE_MASK;
               MUX_ADDR   <= '0;
               scan_state <= IDLE;
            end

            default: begin
               scan_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_input_scanner.sv
// Scoreboard bench for mux_input_scanner: a mux model drives MUX_OUT from an input vector,
// each scan's expected image/mask is queued when driven and popped at SCAN_DONE.
module tb_mux_input_scanner;

   localparam int NUM      = 16;
   localparam int PERIOD_A = 200;
   localparam int PERIOD_B = 60;
   localparam int SETTLE   = 4;
   localparam int DEB      = 3;

   typedef struct packed {
      logic [15:0] st;
      logic [15:0] mask;
      logic        chg;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  mux_addr_a, mux_addr_b;
   logic        mux_out_a, mux_out_b;
   logic [15:0] state_a, mask_a, state_b, mask_b;
   logic        scan_done_a, changed_a, overrun_a;
   logic        scan_done_b, changed_b, overrun_b;
   logic [15:0] inputs = '0;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int b_done_cnt = 0;
   int last_done  = -1;

   logic [15:0] m_state;
   int          m_cnt [NUM];
   exp_t        sb [$];

   assign mux_out_a = inputs[mux_addr_a];
   assign mux_out_b = 1'b0;

   mux_input_scanner #(
      .NUM_INPUTS(NUM), .ADDR_BITS(4), .SETTLE_CYCLES(SETTLE),
      .DEBOUNCE_SCANS(DEB), .SCAN_PERIOD(PERIOD_A)
   ) dut_a (
      .CLK(CLK), .RESET(RESET), .MUX_ADDR(mux_addr_a), .MUX_OUT(mux_out_a),
      .STATE(state_a), .CHANGE_MASK(mask_a), .SCAN_DONE(scan_done_a),
      .CHANGED(changed_a), .OVERRUN(overrun_a)
   );

   mux_input_scanner #(
      .NUM_INPUTS(NUM), .ADDR_BITS(4), .SETTLE_CYCLES(SETTLE),
      .DEBOUNCE_SCANS(DEB), .SCAN_PERIOD(PERIOD_B)
   ) dut_b (
      .CLK(CLK), .RESET(RESET), .MUX_ADDR(mux_addr_b), .MUX_OUT(mux_out_b),
      .STATE(state_b), .CHANGE_MASK(mask_b), .SCAN_DONE(scan_done_b),
      .CHANGED(changed_b), .OVERRUN(overrun_b)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (scan_done_b) b_done_cnt <= b_done_cnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      m_state = '0;
      for (int i = 0; i < NUM; i++) m_cnt[i] = 0;
      sb.delete();
      last_done = -1;
   endtask

   task automatic waitDoneA(input string tag, output logic seen);
      seen = 1'b0;
      for (int c = 0; c < 2 * PERIOD_A + 50 && !seen; c++) begin
         @(negedge CLK);
         if (scan_done_a) seen = 1'b1;
      end
      checkOutput({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
      if (seen) begin
         if (last_done >= 0) checkOutput({tag, "_period"}, cyc - last_done, PERIOD_A);
         last_done = cyc;
      end
   endtask

   task automatic checkAddrSequence();
      int n;
      for (int c = 0; c < 300 && mux_addr_a != 4'd1; c++) @(negedge CLK);
      checkOutput("addr_reach_1", {28'b0, mux_addr_a}, 32'd1);
      for (int k = 1; k < 15; k++) begin
         n = 0;
         while (mux_addr_a == 4'(k) && n < 20) begin
            n++;
            @(negedge CLK);
         end
         checkOutput($sformatf("addr_%0d_hold", k), n, SETTLE + 1);
         checkOutput($sformatf("addr_%0d_next", k), {28'b0, mux_addr_a}, k + 1);
      end
   endtask

   // One scan: drive the image, queue the expected result, compare when SCAN_DONE fires.
   task automatic applyStimulus(input logic [15:0] vec, input string tag, input bit check_addr);
      exp_t e;
      exp_t got;
      logic seen;
      inputs = vec;
      e.mask = '0;
      for (int i = 0; i < NUM; i++) begin
         if (vec[i] == m_state[i]) begin
            m_cnt[i] = 0;
         end else if (m_cnt[i] == DEB - 1) begin
            m_state[i] = vec[i];
            m_cnt[i]   = 0;
            e.mask[i]  = 1'b1;
         end else begin
            m_cnt[i]++;
         end
      end
      e.st  = m_state;
      e.chg = |e.mask;
      sb.push_back(e);
      if (check_addr) checkAddrSequence();
      waitDoneA(tag, seen);
      got = sb.pop_front();
      if (seen) begin
         checkOutput({tag, "_state"}, {16'b0, state_a}, {16'b0, got.st});
         checkOutput({tag, "_mask"}, {16'b0, mask_a}, {16'b0, got.mask});
         checkOutput({tag, "_changed"}, {31'b0, changed_a}, {31'b0, got.chg});
         checkOutput({tag, "_overrun_a"}, {31'b0, overrun_a}, 32'd0);
         @(negedge CLK);
         checkOutput({tag, "_done_width"}, {31'b0, scan_done_a}, 32'd0);
      end
   endtask

   initial begin
      int n;
      logic seen_b;
      modelReset();
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checkOutput("rst_addr", {28'b0, mux_addr_a}, 32'd0);
      checkOutput("rst_state", {16'b0, state_a}, 32'd0);
      checkOutput("rst_mask", {16'b0, mask_a}, 32'd0);
      checkOutput("rst_done", {31'b0, scan_done_a}, 32'd0);
      checkOutput("rst_overrun", {31'b0, overrun_a}, 32'd0);
      RESET = 1'b0;

      seen_b = 1'b0;
      for (int c = 0; c < 300 && !seen_b; c++) begin
         @(negedge CLK);
         if (scan_done_b) seen_b = 1'b1;
      end
      checkOutput("b_first_done_seen", {31'b0, seen_b}, 32'd1);
      checkOutput("b_overrun_first_scan", {31'b0, overrun_b}, 32'd1);

      applyStimulus(16'h0000, "base0", 1'b1);
      applyStimulus(16'h0000, "base1", 1'b0);

      applyStimulus(16'h0008, "glitch_hi0", 1'b0);
      applyStimulus(16'h0008, "glitch_hi1", 1'b0);
      applyStimulus(16'h0000, "glitch_lo0", 1'b0);
      applyStimulus(16'h0000, "glitch_lo1", 1'b0);
      checkOutput("glitch_state_lit", {16'b0, state_a}, 32'h0);

      applyStimulus(16'h8003, "multi0", 1'b0);
      applyStimulus(16'h8003, "multi1", 1'b0);
      applyStimulus(16'h8003, "multi2", 1'b0);
      checkOutput("multi_state_lit", {16'b0, state_a}, 32'h8003);
      checkOutput("multi_mask_lit", {16'b0, mask_a}, 32'h8003);

      applyStimulus(16'h8023, "step5_0", 1'b0);
      applyStimulus(16'h8023, "step5_1", 1'b0);
      checkOutput("step5_not_yet_lit", {31'b0, state_a[5]}, 32'd0);
      applyStimulus(16'h8023, "step5_2", 1'b0);
      checkOutput("step5_state_lit", {16'b0, state_a}, 32'h8023);
      checkOutput("step5_mask_lit", {16'b0, mask_a}, 32'h0020);
      applyStimulus(16'h8023, "step5_3", 1'b0);
      checkOutput("step5_mask_clear_lit", {16'b0, mask_a}, 32'h0);

      applyStimulus(16'hFFFF, "ones0", 1'b0);
      applyStimulus(16'hFFFF, "ones1", 1'b0);
      applyStimulus(16'hFFFF, "ones2", 1'b0);
      checkOutput("ones_state_lit", {16'b0, state_a}, 32'hFFFF);

      checkOutput("b_scans_complete", {31'b0, (b_done_cnt >= 2)}, 32'd1);
      checkOutput("b_overrun_sticky", {31'b0, overrun_b}, 32'd1);

      n = 0;
      while (mux_addr_a != 4'd7 && n < 400) begin
         n++;
         @(negedge CLK);
      end
      checkOutput("midscan_addr7", {28'b0, mux_addr_a}, 32'd7);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      checkOutput("midrst_addr", {28'b0, mux_addr_a}, 32'd0);
      checkOutput("midrst_state", {16'b0, state_a}, 32'd0);
      checkOutput("midrst_mask", {16'b0, mask_a}, 32'd0);
      checkOutput("midrst_done", {31'b0, scan_done_a}, 32'd0);
      checkOutput("midrst_overrun_b", {31'b0, overrun_b}, 32'd0);
      modelReset();

      n = 0;
      for (int c = 0; c < 150; c++) begin
         @(negedge CLK);
         if (scan_done_a) n++;
      end
      checkOutput("midrst_no_done", n, 0);

      applyStimulus(16'hFFFF, "post0", 1'b0);
      applyStimulus(16'hFFFF, "post1", 1'b0);
      checkOutput("post_not_yet_lit", {16'b0, state_a}, 32'h0);
      applyStimulus(16'hFFFF, "post2", 1'b0);
      checkOutput("post_state_lit", {16'b0, state_a}, 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
